// File: rtl/data_mem_ctrl.sv
// Data-memory controller: single outstanding RV32I load/store with fixed wait states.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module data_mem_ctrl #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [31:0]     mem_q [DEPTH];

    logic            do_access;
    logic [AW+1:0]   acc_addr;
    logic            acc_we;
    logic [2:0]      acc_funct3;
    logic [31:0]     acc_wdata;
    logic            is_byte, is_half, is_word, illegal, acc_err;
    logic [1:0]      off;
    logic [AW-1:0]   idx;
    logic [31:0]     ld_sh, ld_data, st_sh;
    logic [3:0]      be;
    logic            mem_we;
    logic            unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];

    // With zero wait states the access happens on the accept edge, so use the live request.
    always_comb begin
        if (state_q == StIdle) begin
            acc_addr   = req_addr[AW+1:0];
            acc_we     = req_we;
            acc_funct3 = req_funct3;
            acc_wdata  = req_wdata;
        end else begin
            acc_addr   = addr_q;
            acc_we     = we_q;
            acc_funct3 = funct3_q;
            acc_wdata  = wdata_q;
        end
    end

    always_comb begin
        is_byte = (acc_funct3[1:0] == 2'b00);
        is_half = (acc_funct3[1:0] == 2'b01);
        is_word = (acc_funct3 == 3'b010);
        illegal = (acc_funct3 == 3'b011) || (acc_funct3[2:1] == 2'b11) ||
                  (acc_we && acc_funct3[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
        off     = acc_addr[1:0];
        acc_err = illegal || (is_half && acc_addr[0]) || (is_word && (acc_addr[1:0] != 2'b00));
`else
        if (is_word) begin
            off = 2'b00;
        end else if (is_half) begin
            off = {acc_addr[1], 1'b0};
        end else begin
            off = acc_addr[1:0];
        end
        acc_err = illegal;
`endif
        idx   = acc_addr[AW+1:2];
        ld_sh = mem_q[idx] >> {off, 3'b000};
        st_sh = acc_wdata << {off, 3'b000};

        unique case (acc_funct3)
            3'b000:  ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b010:  ld_data = mem_q[idx];
            3'b100:  ld_data = {24'd0, ld_sh[7:0]};
            3'b101:  ld_data = {16'd0, ld_sh[15:0]};
            default: ld_data = 32'd0;
        endcase
        if (acc_err || acc_we) begin
            ld_data = 32'd0;
        end

        if (is_byte) begin
            be = 4'b0001 << off;
        end else if (is_half) begin
            be = 4'b0011 << off;
        end else if (is_word) begin
            be = 4'b1111;
        end else begin
            be = 4'b0000;
        end
        mem_we = do_access && acc_we && !acc_err;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d   = req_addr[AW+1:0];
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    cnt_d    = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d   = StResp;
                        do_access = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = StResp;
                    do_access = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_access) begin
            rdata_d = ld_data;
            err_d   = acc_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Array is deliberately not reset; a store in flight during reset never reaches here
    // because reset forces the FSM out of the commit path.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && be[b]) begin
                mem_q[idx][8*b +: 8] <= st_sh[8*b +: 8];
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed scoreboard bench for data_mem_ctrl: instance A uses 1 wait state, B uses 3.
// Expectations follow DMEM_MISALIGN_TRAP_EN when it is defined.
module tb_data_mem_ctrl;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_we, rsp_ready, sel;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic        req_ready_m, rsp_valid_m, rsp_err_m;
    logic [31:0] rsp_rdata_m;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(64), .WAIT_CYCLES(1)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid & ~sel),
        .req_ready  (a_req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (a_rsp_valid),
        .rsp_ready  (rsp_ready & ~sel),
        .rsp_rdata  (a_rsp_rdata),
        .rsp_err    (a_rsp_err)
    );

    data_mem_ctrl #(.DEPTH(64), .WAIT_CYCLES(3)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid & sel),
        .req_ready  (b_req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (b_rsp_valid),
        .rsp_ready  (rsp_ready & sel),
        .rsp_rdata  (b_rsp_rdata),
        .rsp_err    (b_rsp_err)
    );

    assign req_ready_m = sel ? b_req_ready : a_req_ready;
    assign rsp_valid_m = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_rdata_m = sel ? b_rsp_rdata : a_rsp_rdata;
    assign rsp_err_m   = sel ? b_rsp_err   : a_rsp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction: push expectation, handshake, wait bounded for response, compare.
    // hold > 0 stalls rsp_ready while offering a competing store that must be ignored.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int lat, input int hold, input string tag);
        exp_t e;
        int   n;
        e.rdata = er;
        e.err   = ee;
        e.tag   = tag;
        exp_q.push_back(e);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready_m && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " ready"}, 32'(req_ready_m), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid_m && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " rsp_valid"}, 32'(rsp_valid_m), 32'd1);
        if (lat > 0) check({tag, " latency"}, 32'(n + 1), 32'(lat));
        e = exp_q.pop_front();
        check({e.tag, " rdata"}, rsp_rdata_m, e.rdata);
        check({e.tag, " err"}, 32'(rsp_err_m), 32'(e.err));
        if (hold > 0) begin
            req_we     = 1'b1;
            req_funct3 = 3'b010;
            req_addr   = 32'h10;
            req_wdata  = 32'hFFFF_FFFF;
            req_valid  = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                check({tag, " stall valid"}, 32'(rsp_valid_m), 32'd1);
                check({tag, " stall rdata"}, rsp_rdata_m, e.rdata);
                check({tag, " stall ready"}, 32'(req_ready_m), 32'd0);
            end
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, " valid drop"}, 32'(rsp_valid_m), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        sel        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        rsp_ready  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        #12;
        check("reset req_ready", 32'(a_req_ready), 32'd1);
        check("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("reset rsp_rdata", a_rsp_rdata, 32'd0);
        check("reset rsp_err", 32'(a_rsp_err), 32'd0);
        check("reset b rsp_valid", 32'(b_rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        xact(1'b1, 3'b010, 32'h10,  32'hDEAD_BEEF, 32'h0,         1'b0, 2, 0, "SW 0x10");
        xact(1'b0, 3'b010, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0, "LW 0x10");
        xact(1'b1, 3'b000, 32'h11,  32'h0000_0080, 32'h0,         1'b0, 0, 0, "SB 0x11");
        xact(1'b0, 3'b000, 32'h11,  32'h0,         32'hFFFF_FF80, 1'b0, 0, 0, "LB 0x11");
        xact(1'b0, 3'b100, 32'h11,  32'h0,         32'h0000_0080, 1'b0, 0, 0, "LBU 0x11");
        xact(1'b0, 3'b010, 32'h10,  32'h0,         32'hDEAD_80EF, 1'b0, 0, 0, "LW merged");
        xact(1'b1, 3'b010, 32'h100, 32'h1234_5678, 32'h0,         1'b0, 0, 0, "SW 0x100");
        xact(1'b0, 3'b010, 32'h000, 32'h0,         32'h1234_5678, 1'b0, 0, 0, "LW wrap");
        xact(1'b0, 3'b010, 32'h12,  32'h0,
             Trap ? 32'h0 : 32'hDEAD_80EF, Trap, 0, 0, "LW misaligned");
        xact(1'b0, 3'b010, 32'h10,  32'h0,         32'hDEAD_80EF, 1'b0, 0, 5, "LW stall");
        xact(1'b0, 3'b010, 32'h10,  32'h0,         32'hDEAD_80EF, 1'b0, 0, 0, "LW no stray");

        xact(1'b1, 3'b010, 32'h14,  32'h1122_3344, 32'h0,         1'b0, 0, 0, "SW 0x14");
        xact(1'b1, 3'b001, 32'h16,  32'h5555_CAFE, 32'h0,         1'b0, 0, 0, "SH 0x16");
        xact(1'b0, 3'b010, 32'h14,  32'h0,         32'hCAFE_3344, 1'b0, 0, 0, "LW half merge");
        xact(1'b0, 3'b001, 32'h16,  32'h0,         32'hFFFF_CAFE, 1'b0, 0, 0, "LH 0x16");
        xact(1'b0, 3'b101, 32'h16,  32'h0,         32'h0000_CAFE, 1'b0, 0, 0, "LHU 0x16");
        xact(1'b0, 3'b011, 32'h14,  32'h0,         32'h0,         1'b1, 0, 0, "illegal 011");
        xact(1'b0, 3'b111, 32'h14,  32'h0,         32'h0,         1'b1, 0, 0, "illegal 111");
        xact(1'b1, 3'b100, 32'h14,  32'hFFFF_FFFF, 32'h0,         1'b1, 0, 0, "store f3 100");
        xact(1'b0, 3'b010, 32'h14,  32'h0,         32'hCAFE_3344, 1'b0, 0, 0, "LW after bad st");
        xact(1'b0, 3'b001, 32'h17,  32'h0,
             Trap ? 32'h0 : 32'hFFFF_CAFE, Trap, 0, 0, "LH misaligned");

        sel = 1'b1;
        xact(1'b1, 3'b010, 32'h20,  32'h5555_5555, 32'h0,         1'b0, 4, 0, "B SW 0x20");
        // Store abandoned by reset one cycle after its accept edge.
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'hAAAA_AAAA;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("B accepted", 32'(b_req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("B rst rsp_valid", 32'(b_rsp_valid), 32'd0);
        check("B rst req_ready", 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xact(1'b0, 3'b010, 32'h20,  32'h0,         32'h5555_5555, 1'b0, 4, 0, "B LW after rst");
        sel = 1'b0;
        xact(1'b0, 3'b010, 32'h10,  32'h0,         32'hDEAD_80EF, 1'b0, 2, 0, "A mem kept");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, giving memory size in 32-bit words; it SHALL be a power of two, at least 4.
REQ-002 The module SHALL have parameter WAIT_CYCLES, default 1, giving extra access-latency cycles (0..15).
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port req_valid, input, 1 bit: request present.
REQ-006 The module SHALL have port req_ready, output, 1 bit: request accepted this cycle when high together with req_valid.
REQ-007 The module SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The module SHALL have port req_funct3, input, 3 bits: access size and signedness in RV32I encoding.
REQ-009 The module SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The module SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 The module SHALL have port rsp_valid, output, 1 bit: response present.
REQ-012 The module SHALL have port rsp_ready, input, 1 bit: response consumed when high together with rsp_valid.
REQ-013 The module SHALL have port rsp_rdata, output, 32 bits: load result after extension; 0 for stores and errors.
REQ-014 The module SHALL have port rsp_err, output, 1 bit: access fault.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 On a request handshake in IDLE, the block SHALL capture addr, we, funct3 and wdata, load the wait counter with WAIT_CYCLES, and go to WAIT, or directly to RESP if WAIT_CYCLES = 0.
REQ-017 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP when the counter equals 1.
REQ-018 The memory access (store commit or load sample) SHALL occur only on the transition into RESP, so rsp_valid is first high WAIT_CYCLES+1 cycles after the accept edge.
REQ-019 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be held stable until rsp_ready; on that handshake the FSM SHALL return to IDLE and rsp_valid SHALL drop the next cycle.
REQ-020 Word index SHALL be addr[log2(DEPTH)+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-021 funct3 decoding SHALL be: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned; 011, 110 and 111 SHALL be illegal.
REQ-022 An illegal funct3, or a store with funct3 100 or 101, SHALL give rsp_err = 1, rsp_rdata = 0, and no memory write.
REQ-023 Loads SHALL select byte lane addr[1:0] or half lane addr[1], then sign-extend (000, 001) or zero-extend (100, 101).
REQ-024 Stores SHALL write only the addressed byte or half lanes from the low bits of wdata, and other bytes of the word SHALL remain unchanged.
REQ-025 A request SHALL be misaligned when a half access has addr[0] = 1, or a word access has addr[1:0] != 0.
REQ-026 req_valid while not in IDLE SHALL be ignored; only one transaction SHALL be outstanding at a time.

Reset
REQ-027 Asserting rst_n low SHALL immediately force: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, counter 0.
REQ-028 Memory array contents SHALL NOT be reset.
REQ-029 Reset during WAIT SHALL abandon the transaction; a pending store SHALL NOT commit.

Configuration
REQ-030 When macro DMEM_MISALIGN_TRAP_EN is defined, a misaligned access SHALL give rsp_err = 1, rsp_rdata = 0, and no write.
REQ-031 When DMEM_MISALIGN_TRAP_EN is undefined, misaligned offset bits SHALL be forced to zero (half: addr[0]; word: addr[1:0]), the access SHALL proceed, and rsp_err SHALL flag only illegal funct3.

Verification
REQ-032 The bench SHALL check: WAIT_CYCLES=1; SW 0xDEADBEEF to 0x10, then LW 0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid 2 cycles after accept.
REQ-033 The bench SHALL check: after REQ-032, SB wdata 0x00000080 to 0x11; LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-034 The bench SHALL check: DEPTH=64; SW 0x12345678 to 0x100, then LW 0x000 -> 0x12345678 (wrap-around).
REQ-035 The bench SHALL check: LW 0x12 -> with macro, err 1 and rdata 0; without macro, rdata equals word at 0x10 and err 0.
REQ-036 The bench SHALL check: rsp_ready held low 5 cycles -> rsp_valid stays 1, rdata stable, req_ready 0, and concurrent req_valid is not accepted.
REQ-037 The bench SHALL check: WAIT_CYCLES=3; SW 0xAAAAAAAA to 0x20, with rst_n pulsed low 1 cycle after accept -> LW 0x20 returns the prior value.
